fp16_mul_post: RTL and testbench

- Downstream stage of the FP16 mantissa multiplier datapath. Consumes the full 22-bit 11b×11b mantissa product from the Wallace tree, plus unpacked sign/exponent/class fields of both operands.
- Normalizes, rounds RNE, applies special-value rules and packs an IEEE FP16 result.
- Two-stage registered pipeline with valid/ready handshake on both sides; sits between the Wallace tree and the FP writeback/accumulate logic.

---
 rtl/fp16_pkg.sv | 32 +++
 rtl/fp16_round_rne.sv | 29 ++
 rtl/fp16_mul_post.sv | 206 ++++++++++++++++++++
 tb/tb_fp16_mul_post.sv | 482 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp16_pkg.sv
// Shared types and constants for the FP16 multiplier post-processing stage:
// operand classes, field widths, canonical encodings and the stage-1 pipeline record.
package fp16_pkg;

   localparam int BIAS   = 15;
   localparam int EXP_W  = 5;
   localparam int FRAC_W = 10;
   localparam int MANT_W = FRAC_W + 1;
   localparam int PROD_W = 2 * MANT_W;
   localparam int EXPS_W = 8;

   localparam logic [15:0] FP16_QNAN    = 16'h7E00;
   localparam logic [15:0] FP16_INF_MAG = 16'h7C00;

   typedef enum logic [1:0] {
      ZERO = 2'd0,
      NORM = 2'd1,
      INF  = 2'd2,
      NAN  = 2'd3
   } fp_class_t;

   typedef struct packed {
      logic                     sign;
      logic signed [EXPS_W-1:0] exp;
      logic [FRAC_W-1:0]        frac;
      logic                     guard;
      logic                     sticky;
      logic                     special;
      logic [15:0]              special_val;
   } s1_t;

endpackage

// File: rtl/fp16_round_rne.sv
// Round-to-nearest-even on a 10-bit fraction with guard/sticky; carry flags a
// fraction wrap that the caller turns into an exponent increment.
module fp16_round_rne
   import fp16_pkg::*;
(
   input  logic [FRAC_W-1:0] frac_in,
   input  logic              guard,
   input  logic              sticky,
   output logic [FRAC_W-1:0] frac_out,
   output logic              carry
);

   function automatic logic [FRAC_W:0] rne_round(input logic [FRAC_W-1:0] frac,
                                                 input logic              g,
                                                 input logic              s);
      logic round_up;
      round_up = g & (s | frac[0]);
      return {1'b0, frac} + {{FRAC_W{1'b0}}, round_up};
   endfunction

   logic [FRAC_W:0] sum;

   always_comb begin
      sum      = rne_round(frac_in, guard, sticky);
      frac_out = sum[FRAC_W-1:0];
      carry    = sum[FRAC_W];
   end

endmodule

// File: rtl/fp16_mul_post.sv
// FP16 multiply post-stage: normalize, RNE round, special values and pack, two registered stages.
// Build option FP16_MUL_POST_SUBNORM_EN enables gradual underflow; otherwise tiny results flush to zero.
module fp16_mul_post
   import fp16_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic              in_sign_a,
   input  logic              in_sign_b,
   input  logic [EXP_W-1:0]  in_exp_a,
   input  logic [EXP_W-1:0]  in_exp_b,
   input  logic [1:0]        in_cls_a,
   input  logic [1:0]        in_cls_b,
   input  logic [PROD_W-1:0] in_prod,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [15:0]       out_result,
   output logic              out_overflow,
   output logic              out_underflow,
   output logic              out_inexact
);

   localparam logic signed [EXPS_W-1:0] BIAS_S  = EXPS_W'(BIAS);
   localparam logic signed [EXPS_W-1:0] EXP_MAX = EXPS_W'((1 << EXP_W) - 1);

   logic rdy_en;
   logic vld_p1;
   logic vld_p2;
   logic s1_adv;
   logic s2_adv;

   s1_t  s1_p0;
   s1_t  s1_p1;
   logic norm_p0;
   logic any_nan_p0;
   logic any_inf_p0;
   logic any_zero_p0;

   logic [15:0] res_p1;
   logic        ovf_p1;
   logic        unf_p1;
   logic        inx_p1;
   logic [15:0] res_p2;
   logic        ovf_p2;
   logic        unf_p2;
   logic        inx_p2;

   logic signed [EXPS_W-1:0] exp_p1;
   logic signed [EXPS_W-1:0] exp_rnd_p1;
   logic [FRAC_W-1:0]        frac_rnd_p1;
   logic                     carry_p1;

   assign s2_adv    = !vld_p2 || out_ready;
   assign s1_adv    = !vld_p1 || s2_adv;
   assign in_ready  = rdy_en && s1_adv;
   assign out_valid = vld_p2;

   assign out_result    = res_p2;
   assign out_overflow  = ovf_p2;
   assign out_underflow = unf_p2;
   assign out_inexact   = inx_p2;

   // ---- stage 1: normalize product, classify specials ----
   always_comb begin
      any_nan_p0  = (in_cls_a == NAN)  || (in_cls_b == NAN);
      any_inf_p0  = (in_cls_a == INF)  || (in_cls_b == INF);
      any_zero_p0 = (in_cls_a == ZERO) || (in_cls_b == ZERO);
      norm_p0     = in_prod[PROD_W-1];

      s1_p0      = '0;
      s1_p0.sign = in_sign_a ^ in_sign_b;
      if (norm_p0) begin
         s1_p0.frac   = in_prod[PROD_W-2 -: FRAC_W];
         s1_p0.guard  = in_prod[PROD_W-2-FRAC_W];
         s1_p0.sticky = |in_prod[PROD_W-3-FRAC_W:0];
      end else begin
         s1_p0.frac   = in_prod[PROD_W-3 -: FRAC_W];
         s1_p0.guard  = in_prod[PROD_W-3-FRAC_W];
         s1_p0.sticky = |in_prod[PROD_W-4-FRAC_W:0];
      end
      s1_p0.exp = $signed({3'b000, in_exp_a}) + $signed({3'b000, in_exp_b})
                - BIAS_S + $signed({7'b0000000, norm_p0});

      if (any_nan_p0 || (any_inf_p0 && any_zero_p0)) begin
         s1_p0.special     = 1'b1;
         s1_p0.special_val = FP16_QNAN;
      end else if (any_inf_p0) begin
         s1_p0.special     = 1'b1;
         s1_p0.special_val = {s1_p0.sign, FP16_INF_MAG[14:0]};
      end else if (any_zero_p0) begin
         s1_p0.special     = 1'b1;
         s1_p0.special_val = {s1_p0.sign, 15'h0000};
      end
   end

   // rdy_en keeps in_ready low until the first clock after reset release
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdy_en <= 1'b0;
         vld_p1 <= 1'b0;
      end else begin
         rdy_en <= 1'b1;
         if (s1_adv) begin
            vld_p1 <= in_valid && rdy_en;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (in_valid && in_ready) begin
         s1_p1 <= s1_p0;
      end
   end

   // ---- stage 2: round, range check, pack ----
   assign exp_p1 = s1_p1.exp;

   fp16_round_rne u_rnd_norm (
      .frac_in  (s1_p1.frac),
      .guard    (s1_p1.guard),
      .sticky   (s1_p1.sticky),
      .frac_out (frac_rnd_p1),
      .carry    (carry_p1)
   );

   assign exp_rnd_p1 = exp_p1 + $signed({7'b0000000, carry_p1});

`ifdef FP16_MUL_POST_SUBNORM_EN
   // Denormalize {1,frac} by (1 - exp), capped so everything past 11 positions lands in sticky.
   function automatic logic [FRAC_W+1:0] subnorm_align(input logic [FRAC_W-1:0]        frac,
                                                       input logic                     g,
                                                       input logic                     s,
                                                       input logic signed [EXPS_W-1:0] exp);
      logic signed [EXPS_W-1:0] neg;
      logic [3:0]               sh_m1;
      logic [22:0]              w;
      neg   = -exp;
      sh_m1 = (neg > 8'sd11) ? 4'd11 : neg[3:0];
      w     = {1'b1, frac, g, 11'b0} >> sh_m1;
      return {w[22:13], w[12], (|w[11:0]) | s};
   endfunction

   logic [FRAC_W+1:0] sub_aln_p1;
   logic [FRAC_W-1:0] sub_frac_p1;
   logic              sub_carry_p1;

   assign sub_aln_p1 = subnorm_align(s1_p1.frac, s1_p1.guard, s1_p1.sticky, exp_p1);

   fp16_round_rne u_rnd_sub (
      .frac_in  (sub_aln_p1[FRAC_W+1:2]),
      .guard    (sub_aln_p1[1]),
      .sticky   (sub_aln_p1[0]),
      .frac_out (sub_frac_p1),
      .carry    (sub_carry_p1)
   );
`endif

   // Underflow is judged on the pre-rounding exponent; overflow after the rounding carry.
   always_comb begin
      res_p1 = '0;
      ovf_p1 = 1'b0;
      unf_p1 = 1'b0;
      inx_p1 = 1'b0;
      if (s1_p1.special) begin
         res_p1 = s1_p1.special_val;
      end else if (exp_p1 <= 8'sd0) begin
`ifdef FP16_MUL_POST_SUBNORM_EN
         res_p1 = {s1_p1.sign, 4'b0000, sub_carry_p1, sub_frac_p1};
         inx_p1 = sub_aln_p1[1] | sub_aln_p1[0];
         unf_p1 = inx_p1;
`else
         res_p1 = {s1_p1.sign, 15'h0000};
         unf_p1 = 1'b1;
         inx_p1 = 1'b1;
`endif
      end else if (exp_rnd_p1 >= EXP_MAX) begin
         res_p1 = {s1_p1.sign, FP16_INF_MAG[14:0]};
         ovf_p1 = 1'b1;
         inx_p1 = 1'b1;
      end else begin
         res_p1 = {s1_p1.sign, exp_rnd_p1[EXP_W-1:0], frac_rnd_p1};
         inx_p1 = s1_p1.guard | s1_p1.sticky;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2 <= 1'b0;
         res_p2 <= '0;
         ovf_p2 <= 1'b0;
         unf_p2 <= 1'b0;
         inx_p2 <= 1'b0;
      end else if (s2_adv) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            res_p2 <= res_p1;
            ovf_p2 <= ovf_p1;
            unf_p2 <= unf_p1;
            inx_p2 <= inx_p1;
         end
      end
   end

endmodule

// File: tb/tb_fp16_mul_post.sv
// Bench for fp16_mul_post: directed table, specials, streaming with backpressure,
// randomized ops against a value-level reference model, and reset during traffic.
module tb_fp16_mul_post;

   localparam logic [1:0] C_ZERO = 2'd0;
   localparam logic [1:0] C_NORM = 2'd1;
   localparam logic [1:0] C_INF  = 2'd2;
   localparam logic [1:0] C_NAN  = 2'd3;

   typedef struct packed {
      logic        sa;
      logic        sb;
      logic [4:0]  ea;
      logic [4:0]  eb;
      logic [1:0]  ca;
      logic [1:0]  cb;
      logic [21:0] prod;
   } op_t;

   typedef struct packed {
      logic [15:0] r;
      logic        ov;
      logic        un;
      logic        ix;
   } res_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic        in_sign_a, in_sign_b;
   logic [4:0]  in_exp_a, in_exp_b;
   logic [1:0]  in_cls_a, in_cls_b;
   logic [21:0] in_prod;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_result;
   logic        out_overflow, out_underflow, out_inexact;

   int n_checks;
   int n_fail;

   op_t  ops[$];
   res_t got[$];
   int   acc_cyc[$];
   int   got_cyc[$];
   int   first_block;
   int   cycles_used;
   int   hold_err;

   always #5 clk = ~clk;

   fp16_mul_post dut (
      .clk           (clk),
      .rst           (rst),
      .in_valid      (in_valid),
      .in_ready      (in_ready),
      .in_sign_a     (in_sign_a),
      .in_sign_b     (in_sign_b),
      .in_exp_a      (in_exp_a),
      .in_exp_b      (in_exp_b),
      .in_cls_a      (in_cls_a),
      .in_cls_b      (in_cls_b),
      .in_prod       (in_prod),
      .out_valid     (out_valid),
      .out_ready     (out_ready),
      .out_result    (out_result),
      .out_overflow  (out_overflow),
      .out_underflow (out_underflow),
      .out_inexact   (out_inexact)
   );

   // Reference: exact value prod * 2^(ea+eb-30-20), rounded to nearest-even at the target ulp.
   function automatic res_t model(input op_t o);
      res_t   r;
      logic   s;
      int     e;
      int     drop;
      int     k;
      longint p, sig, rem, half;
      bit     up;
      r = '0;
      s = o.sa ^ o.sb;
      if (o.ca == C_NAN || o.cb == C_NAN ||
          (o.ca == C_INF && o.cb == C_ZERO) || (o.ca == C_ZERO && o.cb == C_INF)) begin
         r.r = 16'h7E00;
         return r;
      end
      if (o.ca == C_INF || o.cb == C_INF) begin
         r.r = {s, 15'h7C00};
         return r;
      end
      if (o.ca == C_ZERO || o.cb == C_ZERO) begin
         r.r = {s, 15'h0000};
         return r;
      end
      p    = longint'(o.prod);
      drop = (p >= (longint'(1) << 21)) ? 11 : 10;
      e    = int'(o.ea) + int'(o.eb) - 15 + (drop - 10);
      k    = 26 - int'(o.ea) - int'(o.eb);
      if (e <= 0) begin
`ifdef FP16_MUL_POST_SUBNORM_EN
         sig  = p >> k;
         rem  = p - (sig << k);
         half = longint'(1) << (k - 1);
         up   = (rem > half) || (rem == half && sig[0]);
         sig  = sig + longint'(up);
         r.r  = {s, 15'(sig)};
         r.ix = (rem != 0);
         r.un = r.ix;
`else
         r.r  = {s, 15'h0000};
         r.un = 1'b1;
         r.ix = 1'b1;
`endif
         return r;
      end
      sig  = p >> drop;
      rem  = p & ((longint'(1) << drop) - 1);
      half = longint'(1) << (drop - 1);
      up   = (rem > half) || (rem == half && sig[0]);
      sig  = sig + longint'(up);
      if (sig == 2048) begin
         sig = 1024;
         e   = e + 1;
      end
      r.ix = (rem != 0);
      if (e >= 31) begin
         r.r  = {s, 15'h7C00};
         r.ov = 1'b1;
         r.ix = 1'b1;
      end else begin
         r.r = {s, 5'(e), 10'(sig - 1024)};
      end
      return r;
   endfunction

   function automatic logic [4:0] rand_exp();
      case ($urandom_range(0, 3))
         0:       return 5'($urandom_range(1, 30));
         1:       return 5'($urandom_range(1, 10));
         2:       return 5'($urandom_range(22, 30));
         default: return 5'($urandom_range(12, 18));
      endcase
   endfunction

   function automatic op_t rand_op(input bit allow_special);
      op_t          o;
      logic [10:0]  ma, mb;
      o.sa = 1'($urandom_range(0, 1));
      o.sb = 1'($urandom_range(0, 1));
      o.ea = rand_exp();
      o.eb = rand_exp();
      o.ca = C_NORM;
      o.cb = C_NORM;
      ma   = 11'(1024 + $urandom_range(0, 1023));
      mb   = 11'(1024 + $urandom_range(0, 1023));
      o.prod = 22'(ma * mb);
      if ($urandom_range(0, 5) == 0) begin
         o.prod = 22'(($urandom_range(22'h100000, 22'h3FFFFF) & 32'hFFFFFC00) | 32'h200);
      end
      if (allow_special && $urandom_range(0, 9) == 0) begin
         o.ca = 2'($urandom_range(0, 3));
         o.cb = 2'($urandom_range(0, 3));
      end
      return o;
   endfunction

   task automatic drive(input op_t o);
      in_sign_a = o.sa;
      in_sign_b = o.sb;
      in_exp_a  = o.ea;
      in_exp_b  = o.eb;
      in_cls_a  = o.ca;
      in_cls_b  = o.cb;
      in_prod   = o.prod;
   endtask

   // Drives ops[] through the DUT and collects results; mode 0 = free flow,
   // mode 1 = out_ready low for the first 3 cycles, mode 2 = random gaps on both sides.
   task automatic stream(input int mode);
      int          idx;
      int          cyc;
      bit          prev_stall;
      logic [18:0] prev_out;
      idx = 0;
      cyc = 0;
      prev_stall = 1'b0;
      prev_out = '0;
      hold_err = 0;
      first_block = -1;
      got.delete();
      acc_cyc.delete();
      got_cyc.delete();
      while (got.size() < ops.size() && cyc < 4000) begin
         @(negedge clk);
         case (mode)
            0:       out_ready = 1'b1;
            1:       out_ready = (cyc >= 3);
            default: out_ready = ($urandom_range(0, 3) != 0);
         endcase
         if (idx < ops.size() && (mode != 2 || $urandom_range(0, 4) != 0)) begin
            drive(ops[idx]);
            in_valid = 1'b1;
         end else begin
            in_valid = 1'b0;
         end
         #1;
         if (prev_stall && {out_result, out_overflow, out_underflow, out_inexact} !== prev_out)
            hold_err++;
         prev_stall = out_valid && !out_ready;
         prev_out   = {out_result, out_overflow, out_underflow, out_inexact};
         if (out_valid && out_ready) begin
            got.push_back(res_t'({out_result, out_overflow, out_underflow, out_inexact}));
            got_cyc.push_back(cyc);
         end
         if (in_valid && in_ready) begin
            acc_cyc.push_back(cyc);
            idx++;
         end else if (in_valid && first_block < 0) begin
            first_block = idx;
         end
         cyc++;
      end
      cycles_used = cyc;
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(negedge clk);
      #1;
      n_checks++;
      if ({out_valid, out_result, out_overflow, out_underflow, out_inexact} !== 20'h0) begin
         n_fail++;
         $display("FAIL reset_outputs: got valid=%b res=%h flags=%b%b%b want all zero",
                  out_valid, out_result, out_overflow, out_underflow, out_inexact);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_in_ready: got %b want 0", in_ready);
      end
      @(negedge clk);
      rst = 1'b0;
      #1;
      n_checks++;
      if (in_ready !== 1'b0) begin
         n_fail++;
         $display("FAIL in_ready_at_release: got %b want 0", in_ready);
      end
      @(negedge clk);
      #1;
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL in_ready_after_release: got %b want 1", in_ready);
      end
   endtask

   task automatic test_directed();
      res_t exp_q[$];
      ops.delete();
      //            sa    sb    ea     eb     ca      cb      prod
      ops.push_back({1'b0, 1'b0, 5'd15, 5'd15, C_NORM, C_NORM, 22'h100000}); exp_q.push_back({16'h3C00, 3'b000});
      ops.push_back({1'b0, 1'b0, 5'd15, 5'd15, C_NORM, C_NORM, 22'h240000}); exp_q.push_back({16'h4080, 3'b000});
      ops.push_back({1'b0, 1'b0, 5'd15, 5'd15, C_NORM, C_NORM, 22'h180600}); exp_q.push_back({16'h3E02, 3'b001});
      ops.push_back({1'b0, 1'b0, 5'd30, 5'd30, C_NORM, C_NORM, 22'h100000}); exp_q.push_back({16'h7C00, 3'b101});
      ops.push_back({1'b0, 1'b0, 5'd1,  5'd1,  C_NORM, C_NORM, 22'h100000}); exp_q.push_back({16'h0000, 3'b011});
      ops.push_back({1'b0, 1'b0, 5'd15, 5'd15, C_NORM, C_NORM, 22'h1FFFFF}); exp_q.push_back({16'h4000, 3'b001});
      ops.push_back({1'b0, 1'b0, 5'd15, 5'd15, C_NORM, C_NORM, 22'h100200}); exp_q.push_back({16'h3C00, 3'b001});
      ops.push_back({1'b1, 1'b0, 5'd15, 5'd15, C_NORM, C_NORM, 22'h100000}); exp_q.push_back({16'hBC00, 3'b000});
      ops.push_back({1'b0, 1'b0, 5'd30, 5'd15, C_NORM, C_NORM, 22'h1FFFFF}); exp_q.push_back({16'h7C00, 3'b101});
      ops.push_back({1'b0, 1'b0, 5'd30, 5'd15, C_NORM, C_NORM, 22'h100000}); exp_q.push_back({16'h7800, 3'b000});
      ops.push_back({1'b0, 1'b0, 5'd1,  5'd15, C_NORM, C_NORM, 22'h100000}); exp_q.push_back({16'h0400, 3'b000});
`ifdef FP16_MUL_POST_SUBNORM_EN
      ops.push_back({1'b0, 1'b0, 5'd1,  5'd14, C_NORM, C_NORM, 22'h100000}); exp_q.push_back({16'h0200, 3'b000});
`else
      ops.push_back({1'b0, 1'b0, 5'd1,  5'd14, C_NORM, C_NORM, 22'h100000}); exp_q.push_back({16'h0000, 3'b011});
`endif
      ops.push_back({1'b0, 1'b0, 5'd15, 5'd15, C_NORM, C_NORM, 22'h200C00}); exp_q.push_back({16'h4002, 3'b001});
      stream(0);
      n_checks++;
      if (got.size() != ops.size()) begin
         n_fail++;
         $display("FAIL directed_count: got %0d results want %0d", got.size(), ops.size());
      end
      for (int i = 0; i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL directed[%0d]: got %h flags(ov,un,ix)=%b%b%b want %h flags=%b%b%b", i,
                     got[i].r, got[i].ov, got[i].un, got[i].ix,
                     exp_q[i].r, exp_q[i].ov, exp_q[i].un, exp_q[i].ix);
         end
      end
      if (got.size() > 0) begin
         n_checks++;
         if (got_cyc[0] - acc_cyc[0] != 2) begin
            n_fail++;
            $display("FAIL latency: got %0d cycles want 2", got_cyc[0] - acc_cyc[0]);
         end
      end
   endtask

   task automatic test_specials();
      res_t exp_q[$];
      ops.delete();
      ops.push_back({1'b0, 1'b0, 5'd31, 5'd15, C_NAN,  C_NORM, 22'h100000}); exp_q.push_back({16'h7E00, 3'b000});
      ops.push_back({1'b1, 1'b0, 5'd15, 5'd31, C_NORM, C_NAN,  22'h100000}); exp_q.push_back({16'h7E00, 3'b000});
      ops.push_back({1'b0, 1'b1, 5'd31, 5'd0,  C_INF,  C_ZERO, 22'h000000}); exp_q.push_back({16'h7E00, 3'b000});
      ops.push_back({1'b0, 1'b0, 5'd0,  5'd31, C_ZERO, C_INF,  22'h000000}); exp_q.push_back({16'h7E00, 3'b000});
      ops.push_back({1'b1, 1'b0, 5'd31, 5'd30, C_INF,  C_NORM, 22'h100000}); exp_q.push_back({16'hFC00, 3'b000});
      ops.push_back({1'b1, 1'b1, 5'd31, 5'd31, C_INF,  C_INF,  22'h100000}); exp_q.push_back({16'h7C00, 3'b000});
      ops.push_back({1'b1, 1'b0, 5'd0,  5'd1,  C_ZERO, C_NORM, 22'h000000}); exp_q.push_back({16'h8000, 3'b000});
      ops.push_back({1'b1, 1'b1, 5'd30, 5'd0,  C_NORM, C_ZERO, 22'h000000}); exp_q.push_back({16'h0000, 3'b000});
      stream(0);
      n_checks++;
      if (got.size() != ops.size()) begin
         n_fail++;
         $display("FAIL specials_count: got %0d want %0d", got.size(), ops.size());
      end
      for (int i = 0; i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== exp_q[i]) begin
            n_fail++;
            $display("FAIL special[%0d]: got %h flags=%b%b%b want %h flags=%b%b%b", i,
                     got[i].r, got[i].ov, got[i].un, got[i].ix,
                     exp_q[i].r, exp_q[i].ov, exp_q[i].un, exp_q[i].ix);
         end
      end
   endtask

   task automatic test_back_to_back();
      ops.delete();
      for (int i = 0; i < 8; i++) ops.push_back(rand_op(1'b0));
      stream(0);
      n_checks++;
      if (cycles_used != 10 || first_block != -1) begin
         n_fail++;
         $display("FAIL throughput: got %0d cycles block_at=%0d want 10 cycles block_at=-1",
                  cycles_used, first_block);
      end
      for (int i = 0; i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== model(ops[i])) begin
            n_fail++;
            $display("FAIL b2b[%0d]: got %h want %h", i, got[i], model(ops[i]));
         end
      end
   endtask

   task automatic test_backpressure();
      ops.delete();
      for (int i = 0; i < 4; i++) ops.push_back(rand_op(1'b0));
      stream(1);
      n_checks++;
      if (first_block != 2) begin
         n_fail++;
         $display("FAIL bp_in_ready_drop: got block after %0d accepts want 2", first_block);
      end
      n_checks++;
      if (hold_err != 0) begin
         n_fail++;
         $display("FAIL bp_hold_stable: got %0d changes while stalled want 0", hold_err);
      end
      n_checks++;
      if (got.size() != 4) begin
         n_fail++;
         $display("FAIL bp_count: got %0d want 4", got.size());
      end
      for (int i = 0; i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== model(ops[i])) begin
            n_fail++;
            $display("FAIL bp[%0d]: got %h want %h", i, got[i], model(ops[i]));
         end
      end
   endtask

   task automatic test_random();
      int bad;
      ops.delete();
      for (int i = 0; i < 300; i++) ops.push_back(rand_op(1'b1));
      stream(2);
      n_checks++;
      if (got.size() != ops.size()) begin
         n_fail++;
         $display("FAIL random_count: got %0d want %0d", got.size(), ops.size());
      end
      n_checks++;
      if (hold_err != 0) begin
         n_fail++;
         $display("FAIL random_hold_stable: got %0d changes while stalled want 0", hold_err);
      end
      bad = 0;
      for (int i = 0; i < got.size(); i++) begin
         n_checks++;
         if (got[i] !== model(ops[i])) begin
            n_fail++;
            bad++;
            if (bad <= 10)
               $display("FAIL random[%0d]: ea=%0d eb=%0d prod=%h cls=%0d/%0d got %h want %h", i,
                        ops[i].ea, ops[i].eb, ops[i].prod, ops[i].ca, ops[i].cb,
                        got[i], model(ops[i]));
         end
      end
   endtask

   task automatic test_reset_midstream();
      logic pre_valid;
      int   seen;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         drive(rand_op(1'b0));
         in_valid  = 1'b1;
         out_ready = 1'b1;
      end
      @(negedge clk);
      in_valid = 1'b0;
      #1;
      pre_valid = out_valid;
      n_checks++;
      if (pre_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_pre_valid: got %b want 1", pre_valid);
      end
      rst = 1'b1;
      #1;
      n_checks++;
      if ({out_valid, out_result, out_overflow, out_underflow, out_inexact} !== 20'h0) begin
         n_fail++;
         $display("FAIL midrst_clear: got valid=%b res=%h want valid=0 res=0000",
                  out_valid, out_result);
      end
      repeat (2) @(negedge clk);
      rst  = 1'b0;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         #1;
         if (out_valid) seen++;
      end
      n_checks++;
      if (seen != 0) begin
         n_fail++;
         $display("FAIL midrst_no_output: got %0d valid cycles want 0", seen);
      end
      n_checks++;
      if (in_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL midrst_ready_return: got %b want 1", in_ready);
      end
   endtask

   initial begin
      n_checks  = 0;
      n_fail    = 0;
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      drive('0);
      test_reset();
      test_directed();
      test_specials();
      test_back_to_back();
      test_backpressure();
      test_random();
      test_reset_midstream();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

endmodule
